// File: rtl/rhd_pkg.sv
// rhd_pkg: shared opcodes, ROM constants, FSM states and response type for the RHD SPI responder.
// Latency: n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
// Contents: opcode patterns, ROM bytes for the read-only register window, chip ID,
//   writable-register limit, frame edge count, state_e, resp_t, rom_byte(), decode_resp().
package rhd_pkg;

  // Command field patterns (bits 15:14 select the opcode class)
  localparam logic [1:0]  OP_CONVERT    = 2'b00;
  localparam logic [1:0]  OP_WRITE      = 2'b10;
  localparam logic [1:0]  OP_READ       = 2'b11;
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

  // Register map
  localparam int          REG_RW_COUNT       = 40;
  localparam logic [5:0]  REG_WRITABLE_LIMIT = 6'd40;
  localparam logic [7:0]  CHIP_ID            = 8'h04;

  // A frame is exactly this many rising and this many falling SCLK edges
  localparam logic [4:0]  FRAME_EDGES = 5'd16;
  localparam logic [4:0]  EDGE_SAT    = 5'd31;

  typedef enum logic [2:0] {
    ST_WAIT_HI,
    ST_IDLE,
    ST_ACTIVE,
    ST_COMMIT,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } resp_t;

  // Read-only window above the writable registers: "INTAN" then the chip ID at 63
  function automatic logic [7:0] rom_byte(input logic [5:0] addr);
    case (addr)
      6'd40:   rom_byte = 8'h49;
      6'd41:   rom_byte = 8'h4E;
      6'd42:   rom_byte = 8'h54;
      6'd43:   rom_byte = 8'h41;
      6'd44:   rom_byte = 8'h4E;
      6'd63:   rom_byte = CHIP_ID;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  // Response for a committed command word; rdata is the register addressed by cmd[13:8]
  function automatic resp_t decode_resp(input logic [15:0] cmd,
                                        input logic [15:0] adc_a,
                                        input logic [15:0] adc_b,
                                        input logic [7:0]  rdata);
    resp_t r;
    r = '0;
    if (cmd[15:14] == OP_CONVERT) begin
      r.a = adc_a;
      r.b = adc_b;
    end else if (cmd[15:14] == OP_WRITE) begin
      r.a = {8'hFF, cmd[7:0]};
    end else if (cmd[15:14] == OP_READ) begin
      r.a = {8'h00, rdata};
    end else if (cmd == CMD_CALIBRATE || cmd == CMD_CLEAR) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rhd_reg_file.sv
// rhd_reg_file: 64x8 register map, 40 read/write entries plus a read-only ROM overlay above.
// Latency: write takes effect on the next i_clk edge; read is combinational.
// Backpressure: none; writes to addresses >= 40 are silently dropped.
// Ports: i_clk/i_rst clock and async active-low reset; i_we/i_waddr/i_wdata write port;
//   i_raddr/o_rdata combinational read port.
module rhd_reg_file
  import rhd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [5:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] mem_q [REG_RW_COUNT];
  logic [7:0] mem_d [REG_RW_COUNT];

  always_comb begin
    mem_d = mem_q;
    if (i_we && (i_waddr < REG_WRITABLE_LIMIT)) begin
      mem_d[i_waddr] = i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < REG_RW_COUNT; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    if (i_raddr < REG_WRITABLE_LIMIT) begin
      o_rdata = mem_q[i_raddr];
    end else begin
      o_rdata = rom_byte(i_raddr);
    end
  end

endmodule

// File: rtl/rhd_spi_slave.sv
// rhd_spi_slave: RHD2164-style 16-bit SPI responder (CPOL=0) with register file and response pipeline.
// Latency: SCLK/CS pin edge to o_miso 3 i_clk; CS rise to o_cmd_valid/o_frame_err 4 i_clk; reply in frame N+1, or N+2 with RHD_SLAVE_PIPE2_EN.
// Backpressure: none; the SPI master owns pacing, i_clk must give >= 6 cycles per SCLK half-period.
// Ports: i_clk, i_rst (async active-low); i_sclk/i_cs_n/i_mosi async SPI pins; o_miso registered;
//   i_adc_a/i_adc_b CONVERT samples taken in the commit cycle; o_cmd/o_cmd_valid last committed word;
//   o_frame_err pulse on an aborted frame.
// Build option: define RHD_SLAVE_PIPE2_EN for the two-stage response pipeline (chip-accurate latency).
module rhd_spi_slave
  import rhd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  input  logic [15:0] i_adc_a,
  input  logic [15:0] i_adc_b,
  output logic [15:0] o_cmd,
  output logic        o_cmd_valid,
  output logic        o_frame_err
);

  // Synchronizers: bits [1:0] are the 2-FF chain, bit [2] is the previous value for edge detect
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  cs_sync_q,   cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  rise_cnt_q, rise_cnt_d;
  logic [4:0]  fall_cnt_q, fall_cnt_d;
  logic        ddr_q, ddr_d;
  logic        miso_q, miso_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_err_q, frame_err_d;
  resp_t       resp0_q, resp0_d;
`ifdef RHD_SLAVE_PIPE2_EN
  resp_t       resp1_q, resp1_d;
`endif

  resp_t       head;
  resp_t       commit_resp;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign cs_rise   =  cs_sync_q[1]   & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1]   &  cs_sync_q[2];

  // Response being shifted out in the current frame is the oldest pipeline stage
`ifdef RHD_SLAVE_PIPE2_EN
  assign head = resp1_q;
`else
  assign head = resp0_q;
`endif

  assign reg_we      = (state_q == ST_COMMIT) && (shift_q[15:14] == OP_WRITE);
  assign commit_resp = decode_resp(shift_q, i_adc_a, i_adc_b, reg_rdata);

  rhd_reg_file u_reg_file (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (reg_we),
    .i_waddr (shift_q[13:8]),
    .i_wdata (shift_q[7:0]),
    .i_raddr (shift_q[13:8]),
    .o_rdata (reg_rdata)
  );

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], i_sclk};
    cs_sync_d   = {cs_sync_q[1:0], i_cs_n};
    mosi_sync_d = {mosi_sync_q[0], i_mosi};
    state_d     = state_q;
    shift_d     = shift_q;
    rise_cnt_d  = rise_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    ddr_d       = ddr_q;
    miso_d      = 1'b0;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    resp0_d     = resp0_q;
`ifdef RHD_SLAVE_PIPE2_EN
    resp1_d     = resp1_q;
`endif

    case (state_q)
      ST_WAIT_HI: begin
        if (cs_sync_q[1]) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          rise_cnt_d = 5'd0;
          fall_cnt_d = 5'd0;
          miso_d     = head.a[15];
        end
      end

      ST_ACTIVE: begin
        miso_d = miso_q;
        if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = (rise_cnt_q == FRAME_EDGES && fall_cnt_q == FRAME_EDGES) ? ST_COMMIT : ST_ABORT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], mosi_sync_q[1]};
          if (rise_cnt_q != EDGE_SAT) rise_cnt_d = rise_cnt_q + 5'd1;
          if (rise_cnt_q == 5'd0) begin
            // MOSI bit 15 picks the reply format; rising edge 1 keeps A[15] on the line
            ddr_d = ~mosi_sync_q[1];
          end else if (ddr_q && rise_cnt_q < FRAME_EDGES) begin
            // Rising edge n = cnt+1 drives A[17-n] = A[16-cnt]; 4-bit wrap gives 16-cnt
            miso_d = head.a[4'd0 - rise_cnt_q[3:0]];
          end
        end else if (sclk_fall) begin
          if (fall_cnt_q != EDGE_SAT) fall_cnt_d = fall_cnt_q + 5'd1;
          if (ddr_q) begin
            if (fall_cnt_q < FRAME_EDGES) miso_d = head.b[4'd15 - fall_cnt_q[3:0]];
          end else if (fall_cnt_q < 5'd15) begin
            miso_d = head.a[4'd14 - fall_cnt_q[3:0]];
          end
        end
      end

      ST_COMMIT: begin
        state_d     = ST_IDLE;
        cmd_d       = shift_q;
        cmd_valid_d = 1'b1;
        resp0_d     = commit_resp;
`ifdef RHD_SLAVE_PIPE2_EN
        resp1_d     = resp0_q;
`endif
      end

      ST_ABORT: begin
        state_d     = ST_IDLE;
        frame_err_d = 1'b1;
      end

      default: state_d = ST_WAIT_HI;
    endcase
  end

  // CS sync resets low so a chip select held low across reset is never mistaken for idle
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
      state_q     <= ST_WAIT_HI;
      shift_q     <= 16'h0000;
      rise_cnt_q  <= 5'd0;
      fall_cnt_q  <= 5'd0;
      ddr_q       <= 1'b0;
      miso_q      <= 1'b0;
      cmd_q       <= 16'h0000;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      resp0_q     <= '0;
`ifdef RHD_SLAVE_PIPE2_EN
      resp1_q     <= '0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      ddr_q       <= ddr_d;
      miso_q      <= miso_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      resp0_q     <= resp0_d;
`ifdef RHD_SLAVE_PIPE2_EN
      resp1_q     <= resp1_d;
`endif
    end
  end

  assign o_miso      = miso_q;
  assign o_cmd       = cmd_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_rhd_spi_slave.sv
// tb_rhd_spi_slave: directed bench for rhd_spi_slave acting as a bit-banged SPI master.
// Latency: n/a.
// Backpressure: n/a.
module tb_rhd_spi_slave;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_sclk;
  logic        i_cs_n;
  logic        i_mosi;
  logic        o_miso;
  logic [15:0] i_adc_a;
  logic [15:0] i_adc_b;
  logic [15:0] o_cmd;
  logic        o_cmd_valid;
  logic        o_frame_err;

  int checks = 0;
  int errors = 0;

  // Expected response pipeline: stage 0 newest; values pushed are hand-computed per command
  logic [15:0] pa0, pb0, pa1, pb1;
  logic [15:0] last_cmd;

  rhd_spi_slave dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sclk      (i_sclk),
    .i_cs_n      (i_cs_n),
    .i_mosi      (i_mosi),
    .o_miso      (o_miso),
    .i_adc_a     (i_adc_a),
    .i_adc_b     (i_adc_b),
    .o_cmd       (o_cmd),
    .o_cmd_valid (o_cmd_valid),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] head_a();
`ifdef RHD_SLAVE_PIPE2_EN
    return pa1;
`else
    return pa0;
`endif
  endfunction

  function automatic logic [15:0] head_b();
`ifdef RHD_SLAVE_PIPE2_EN
    return pb1;
`else
    return pb0;
`endif
  endfunction

  // Half SCLK period = 8 i_clk; MISO sampled just before the next pin change
  task automatic half(output logic s);
    repeat (8) @(negedge i_clk);
    s = o_miso;
  endtask

  // One chip-select frame with nedges SCLK pulses; push_a/push_b is the reply this
  // command should produce two (or one) frames later if the frame commits.
  task automatic frame(input string tag, input logic [15:0] cmd, input int nedges,
                       input logic [15:0] push_a, input logic [15:0] push_b);
    logic [15:0] ea, eb, an, ad, bd;
    logic        s0, l_before, l_after, smp;
    logic [16:1] r, f;
    int          vpos, vcnt, epos, ecnt;
    ea = head_a();
    eb = head_b();
    r = '0; f = '0; an = '0; ad = '0; bd = '0;
    l_before = 1'b0; l_after = 1'b0;
    vpos = 0; vcnt = 0; epos = 0; ecnt = 0;

    @(posedge i_clk); #1;
    i_cs_n = 1'b0;
    i_mosi = cmd[15];
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      if (k == 3) l_before = o_miso;
      if (k == 4) l_after  = o_miso;
    end
    s0 = o_miso;
    for (int i = 1; i <= nedges; i++) begin
      @(posedge i_clk); #1;
      i_sclk = 1'b1;
      half(smp);
      if (i <= 16) r[i] = smp;
      @(posedge i_clk); #1;
      i_sclk = 1'b0;
      if (i < 16) i_mosi = cmd[15-i];
      half(smp);
      if (i <= 16) f[i] = smp;
    end
    @(posedge i_clk); #1;
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      if (o_cmd_valid) begin vcnt++; if (vpos == 0) vpos = k; end
      if (o_frame_err) begin ecnt++; if (epos == 0) epos = k; end
    end
    chk({tag, "_miso_idle"}, o_miso, 0);

    if (nedges == 16) begin
      chk({tag, "_valid_pos"}, vpos, 5);
      chk({tag, "_valid_cnt"}, vcnt, 1);
      chk({tag, "_err_cnt"}, ecnt, 0);
      chk({tag, "_cmd"}, o_cmd, cmd);
      if (ea[15]) begin
        chk({tag, "_cs_lat_before"}, l_before, 0);
        chk({tag, "_cs_lat_after"}, l_after, 1);
      end
      if (cmd[15]) begin
        an[15] = s0;
        for (int n = 1; n <= 15; n++) an[15-n] = f[n];
        chk({tag, "_norm_a"}, an, ea);
      end else begin
        chk({tag, "_ddr_a15_start"}, {s0, r[1]}, {ea[15], ea[15]});
        for (int n = 2; n <= 16; n++) ad[17-n] = r[n];
        for (int n = 1; n <= 16; n++) bd[16-n] = f[n];
        chk({tag, "_ddr_a"}, ad[15:1], ea[15:1]);
        chk({tag, "_ddr_b"}, bd, eb);
      end
      pa1 = pa0; pb1 = pb0;
      pa0 = push_a; pb0 = push_b;
      last_cmd = cmd;
    end else begin
      chk({tag, "_err_pos"}, epos, 5);
      chk({tag, "_err_cnt"}, ecnt, 1);
      chk({tag, "_valid_cnt"}, vcnt, 0);
      chk({tag, "_cmd_kept"}, o_cmd, last_cmd);
    end
    repeat (4) @(posedge i_clk);
  endtask

  int viol;

  initial begin
    i_rst = 1'b0; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    i_adc_a = 16'h0000; i_adc_b = 16'h0000;
    pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0; last_cmd = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_miso", o_miso, 0);
    chk("rst_cmd", o_cmd, 16'h0000);
    chk("rst_valid", o_cmd_valid, 0);
    chk("rst_err", o_frame_err, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (10) @(posedge i_clk);

    // Three READ 0 frames: pipeline starts at zero, reg0 reads zero
    frame("rd0_1", 16'hC000, 16, 16'h0000, 16'h0000);
    frame("rd0_2", 16'hC000, 16, 16'h0000, 16'h0000);
    frame("rd0_3", 16'hC000, 16, 16'h0000, 16'h0000);

    // WRITE reg10=5C, READ reg10, flush
    frame("wr10",  16'h8A5C, 16, 16'hFF5C, 16'h0000);
    frame("rd10",  16'hCA00, 16, 16'h005C, 16'h0000);
    frame("dmy_a", 16'hC000, 16, 16'h0000, 16'h0000);
    frame("dmy_b", 16'hC000, 16, 16'h0000, 16'h0000);

    // ROM window, chip ID, write to read-only space ignored but echoed
    frame("rd40",  16'hE800, 16, 16'h0049, 16'h0000);
    frame("rd41",  16'hE900, 16, 16'h004E, 16'h0000);
    frame("rd42",  16'hEA00, 16, 16'h0054, 16'h0000);
    frame("rd43",  16'hEB00, 16, 16'h0041, 16'h0000);
    frame("rd44",  16'hEC00, 16, 16'h004E, 16'h0000);
    frame("rd63",  16'hFF00, 16, 16'h0004, 16'h0000);
    frame("wr40",  16'hA8FF, 16, 16'hFFFF, 16'h0000);
    frame("rd40b", 16'hE800, 16, 16'h0049, 16'h0000);
    frame("dmy_c", 16'hC000, 16, 16'h0000, 16'h0000);
    frame("dmy_d", 16'hC000, 16, 16'h0000, 16'h0000);

    // CONVERT in DDR format, samples taken at commit
    i_adc_a = 16'h1234; i_adc_b = 16'hABCD;
    frame("conv1", 16'h0500, 16, 16'h1234, 16'hABCD);
    i_adc_a = 16'h8001; i_adc_b = 16'h7FFE;
    frame("conv2", 16'h0500, 16, 16'h8001, 16'h7FFE);
    i_adc_a = 16'h5A5A; i_adc_b = 16'hC3C3;
    frame("conv3", 16'h0500, 16, 16'h5A5A, 16'hC3C3);
    frame("calib", 16'h5500, 16, 16'h0000, 16'h0000);
    frame("clear", 16'h6A00, 16, 16'h0000, 16'h0000);
    frame("calb2", 16'h5500, 16, 16'h0000, 16'h0000);

    // Aborted frames leave pipeline, registers and o_cmd untouched
    frame("wr1",    16'h8133, 16, 16'hFF33, 16'h0000);
    frame("abrt10", 16'h8177, 10, 16'h0000, 16'h0000);
    frame("glitch", 16'hC000,  0, 16'h0000, 16'h0000);
    frame("extra",  16'h8177, 17, 16'h0000, 16'h0000);
    frame("rd1",    16'hC100, 16, 16'h0033, 16'h0000);
    frame("dmy_e",  16'hC000, 16, 16'h0000, 16'h0000);
    frame("dmy_f",  16'hC000, 16, 16'h0000, 16'h0000);

    // Reset mid-frame with cs_n held low across release
    frame("wr1b", 16'h8155, 16, 16'hFF55, 16'h0000);
    @(posedge i_clk); #1;
    i_cs_n = 1'b0;
    i_mosi = 1'b1;
    repeat (4) begin
      @(posedge i_clk); #1;
      i_sclk = ~i_sclk;
      repeat (8) @(posedge i_clk);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_mid_miso", o_miso, 0);
    chk("rst_mid_cmd", o_cmd, 16'h0000);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0; last_cmd = '0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      i_sclk = ~i_sclk;
      repeat (8) begin
        @(negedge i_clk);
        if (o_cmd_valid || o_frame_err || o_miso) viol++;
      end
    end
    chk("rst_quiet_low", viol, 0);
    @(posedge i_clk); #1;
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    viol = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_cmd_valid || o_frame_err) viol++;
    end
    chk("rst_quiet_rise", viol, 0);
    repeat (4) @(posedge i_clk);
    frame("post_rd1", 16'hC100, 16, 16'h0000, 16'h0000);
    frame("post_d1",  16'hC000, 16, 16'h0000, 16'h0000);
    frame("post_d2",  16'hC000, 16, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
